// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Fetch stage that sits in front of the instruction memory. It owns the
// program counter and presents it as a byte address. The memory answers
// combinationally in the same cycle. The returned word is latched into the
// IF/ID register together with a valid flag.
//
// Decode can redirect the PC with a jump or a taken branch. Redirects are
// honoured only while the word in IF/ID is valid, and a jump beats a branch.
// A stall request freezes the PC and the IF/ID register. When the PC would
// leave the program space (0 .. MEM_BYTES-4), the unit halts until reset.
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous, active-high reset
//   stall           hold PC and IF/ID this cycle
//   branch_taken    decode resolved a taken branch for the IF/ID word
//   branch_offset   signed word offset of that branch
//   jump            decode resolved a J-type jump for the IF/ID word
//   jump_index      26-bit J-type target index
//   Instruction_In  memory word at PC_Read_address (same cycle)
//   PC_Read_address current PC, to the instruction memory
//   Instr_Out       IF/ID instruction register
//   PC_Plus4_Out    IF/ID copy of (fetched PC + 4)
//   instr_valid     Instr_Out holds a real, non-flushed instruction
//   halted          unit has stopped on a range fault
//   fetch_count     number of words latched valid since reset (wraps)
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          MEM_BYTES = 4096,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [15:0]      branch_offset,
   input  logic             jump,
   input  logic [25:0]      jump_index,
   input  logic [31:0]      Instruction_In,
   output logic [31:0]      PC_Read_address,
   output logic [31:0]      Instr_Out,
   output logic [31:0]      PC_Plus4_Out,
   output logic             instr_valid,
   output logic             halted,
   output logic [CNT_W-1:0] fetch_count
);

   // Highest byte address that still holds a whole instruction word.
   localparam logic [31:0] PC_LIMIT = 32'(MEM_BYTES - 4);

   // LAST_WORD is the one cycle after the final legal word was latched by a
   // sequential fetch. It lets decode see that word before the unit halts.
   typedef enum logic [1:0] {
      BOOT      = 2'd0,
      RUN       = 2'd1,
      LAST_WORD = 2'd2,
      HALT      = 2'd3
   } fetch_state_t;

   fetch_state_t     state_q, state_nxt;
   logic [31:0]      pc_q, pc_nxt;
   logic [31:0]      instr_q, instr_nxt;
   logic [31:0]      pc_plus4_q, pc_plus4_nxt;
   logic             valid_q, valid_nxt;
   logic             halted_q, halted_nxt;
   logic [CNT_W-1:0] count_q, count_nxt;

   logic [31:0]      jump_target;
   logic [31:0]      branch_target;
   logic [31:0]      redirect_pc;
   logic [31:0]      seq_pc;
   logic             redirect;

   // Candidate next-PC values. Both redirect targets are relative to the
   // IF/ID copy of PC+4, because that is the instruction decode is looking at.
   // The branch sum wraps at 32 bits. A backward branch past zero therefore
   // becomes a huge address, and the range check treats it as a fault.
   always_comb begin
      jump_target   = {pc_plus4_q[31:28], jump_index, 2'b00};
      branch_target = pc_plus4_q + {{14{branch_offset[15]}}, branch_offset, 2'b00};
      redirect      = valid_q && (jump || branch_taken);
      redirect_pc   = jump ? jump_target : branch_target;
      seq_pc        = pc_q + 32'd4;
   end

   // Next-state and next-register logic. Every register holds by default.
   // Each state overrides only what changes. In RUN, a redirect outranks a
   // stall. A stall outranks a sequential fetch.
   always_comb begin
      state_nxt    = state_q;
      pc_nxt       = pc_q;
      instr_nxt    = instr_q;
      pc_plus4_nxt = pc_plus4_q;
      valid_nxt    = valid_q;
      halted_nxt   = halted_q;
      count_nxt    = count_q;

      case (state_q)
         BOOT: begin
            state_nxt = RUN;
         end

         RUN: begin
            if (redirect) begin
               valid_nxt = 1'b0;
               if (redirect_pc > PC_LIMIT) begin
                  halted_nxt = 1'b1;
                  state_nxt  = HALT;
               end else begin
                  pc_nxt = redirect_pc;
               end
            end else if (!stall) begin
               instr_nxt    = Instruction_In;
               pc_plus4_nxt = seq_pc;
               valid_nxt    = 1'b1;
               count_nxt    = count_q + CNT_W'(1);
               if (seq_pc > PC_LIMIT) begin
                  state_nxt = LAST_WORD;
               end else begin
                  pc_nxt = seq_pc;
               end
            end
         end

         LAST_WORD: begin
            valid_nxt  = 1'b0;
            halted_nxt = 1'b1;
            state_nxt  = HALT;
         end

         HALT: begin
            valid_nxt = 1'b0;
         end

         default: begin
            state_nxt = HALT;
         end
      endcase
   end

   // State and pipeline registers. Reset is asynchronous, so a reset in the
   // middle of a cycle clears IF/ID at once. It does not wait for the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         instr_q    <= 32'd0;
         pc_plus4_q <= 32'd0;
         valid_q    <= 1'b0;
         halted_q   <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_nxt;
         pc_q       <= pc_nxt;
         instr_q    <= instr_nxt;
         pc_plus4_q <= pc_plus4_nxt;
         valid_q    <= valid_nxt;
         halted_q   <= halted_nxt;
         count_q    <= count_nxt;
      end
   end

   assign PC_Read_address = pc_q;
   assign Instr_Out       = instr_q;
   assign PC_Plus4_Out    = pc_plus4_q;
   assign instr_valid     = valid_q;
   assign halted          = halted_q;
   assign fetch_count     = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Bench for pc_fetch_unit with a 128-byte instruction memory. At each falling
// edge the stimulus task drives the inputs. It advances a behavioural model
// of the fetch stage and queues the state the DUT should hold after the next
// rising edge. A separate monitor pops that queue after each rising edge and
// compares the DUT against it.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

   localparam int          MEM_BYTES = 128;
   localparam int          MEM_WORDS = MEM_BYTES / 4;
   localparam logic [31:0] LIMIT     = 32'(MEM_BYTES - 4);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] p4;
      logic        valid;
      logic        halted;
      logic [15:0] cnt;
   } snap_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [15:0] branch_offset = 16'd0;
   logic        jump = 1'b0;
   logic [25:0] jump_index = 26'd0;
   logic [31:0] Instruction_In;
   logic [31:0] PC_Read_address;
   logic [31:0] Instr_Out;
   logic [31:0] PC_Plus4_Out;
   logic        instr_valid;
   logic        halted;
   logic [15:0] fetch_count;

   logic [31:0] mem [MEM_WORDS];

   // Model state. The phase is 0 for boot, 1 for running, 2 when the final
   // word has been handed out, and 3 when halted.
   int          m_phase;
   logic [31:0] m_pc, m_instr, m_p4;
   logic        m_valid, m_halted;
   logic [15:0] m_cnt;

   snap_t exp_q[$];
   int    total = 0;
   int    bad = 0;

   pc_fetch_unit #(
      .RESET_PC (32'h0),
      .MEM_BYTES(MEM_BYTES),
      .CNT_W    (16)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .branch_taken   (branch_taken),
      .branch_offset  (branch_offset),
      .jump           (jump),
      .jump_index     (jump_index),
      .Instruction_In (Instruction_In),
      .PC_Read_address(PC_Read_address),
      .Instr_Out      (Instr_Out),
      .PC_Plus4_Out   (PC_Plus4_Out),
      .instr_valid    (instr_valid),
      .halted         (halted),
      .fetch_count    (fetch_count)
   );

   // Free-running clock with a 10-time-unit period.
   always #5 clk = ~clk;

   // The memory answers combinationally. Addresses outside it return zero.
   always_comb begin
      Instruction_In = 32'd0;
      if (PC_Read_address < MEM_BYTES)
         Instruction_In = mem[PC_Read_address[6:2]];
   end

   function automatic snap_t model_snap();
      snap_t s;
      s.pc     = m_pc;
      s.instr  = m_instr;
      s.p4     = m_p4;
      s.valid  = m_valid;
      s.halted = m_halted;
      s.cnt    = m_cnt;
      return s;
   endfunction

   task automatic model_reset();
      m_phase  = 0;
      m_pc     = 32'd0;
      m_instr  = 32'd0;
      m_p4     = 32'd0;
      m_valid  = 1'b0;
      m_halted = 1'b0;
      m_cnt    = 16'd0;
   endtask

   // One rising edge of the fetch stage, written from its rules. A redirect
   // moves the PC and discards the IF/ID word. Otherwise, unless stalled, the
   // current word is fetched and the PC advances by one word. Any PC beyond
   // the memory stops the unit.
   task automatic model_edge(input logic st, input logic bt, input logic [15:0] bo,
                             input logic jp, input logic [25:0] ji);
      logic [31:0] target;
      logic [31:0] off;
      if (m_phase == 0) begin
         m_phase = 1;
      end else if (m_phase == 1) begin
         if (m_valid && (jp || bt)) begin
            off    = {{16{bo[15]}}, bo};
            target = jp ? {m_p4[31:28], ji, 2'b00} : m_p4 + off * 32'd4;
            m_valid = 1'b0;
            if (target > LIMIT) begin
               m_halted = 1'b1;
               m_phase  = 3;
            end else begin
               m_pc = target;
            end
         end else if (!st) begin
            m_instr = mem[m_pc / 4];
            m_p4    = m_pc + 32'd4;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 16'd1;
            if (m_pc + 32'd4 > LIMIT)
               m_phase = 2;
            else
               m_pc = m_pc + 32'd4;
         end
      end else if (m_phase == 2) begin
         m_valid  = 1'b0;
         m_halted = 1'b1;
         m_phase  = 3;
      end else begin
         m_valid = 1'b0;
      end
   endtask

   task automatic checkOutput(input string name, input snap_t e);
      total++;
      if (PC_Read_address !== e.pc || Instr_Out !== e.instr || PC_Plus4_Out !== e.p4 ||
          instr_valid !== e.valid || halted !== e.halted || fetch_count !== e.cnt) begin
         bad++;
         $display("[TB] FAIL %s @%0t got pc=%h ins=%h p4=%h v=%b h=%b cnt=%0d expected pc=%h ins=%h p4=%h v=%b h=%b cnt=%0d",
                  name, $time, PC_Read_address, Instr_Out, PC_Plus4_Out, instr_valid, halted,
                  fetch_count, e.pc, e.instr, e.p4, e.valid, e.halted, e.cnt);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and queue the expected
   // post-edge state. When reset is requested it is asserted mid-cycle. The
   // outputs are then checked right away, before the next rising edge.
   task automatic applyStimulus(input logic r, input logic st, input logic bt,
                                input logic [15:0] bo, input logic jp,
                                input logic [25:0] ji);
      @(negedge clk);
      stall         = st;
      branch_taken  = bt;
      branch_offset = bo;
      jump          = jp;
      jump_index    = ji;
      if (r) begin
         reset = 1'b1;
         model_reset();
         #1;
         checkOutput("async_reset", model_snap());
      end else begin
         reset = 1'b0;
         model_edge(st, bt, bo, jp, ji);
      end
      exp_q.push_back(model_snap());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0);
   endtask

   // Monitor: after every rising edge, compare the DUT with the oldest queued
   // expectation.
   initial begin
      snap_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("edge", e);
         end
      end
   end

   // Directed scenarios first, then a long randomized run with occasional
   // resets.
   initial begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
      mem[0] = 32'h8C09_0000;
      mem[1] = 32'h8C0A_0004;
      mem[2] = 32'h1149_0004;
      mem[4] = 32'h0800_0008;
      model_reset();

      // Reset, then boot and three sequential fetches.
      applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0);
      idle(4);
      // Taken branch from PC+4=12 with offset 4 goes to 28, then a refill.
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0004, 1'b0, 26'd0);
      idle(1);
      // Jump back to 16 so that IF/ID holds 08000008 with PC+4=20.
      applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 26'h4);
      idle(1);
      // Jump, branch and stall all at once: the jump to 32 wins.
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h0001, 1'b1, 26'h8);
      idle(1);
      // Three stalled cycles, then sequential fetch resumes.
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 26'd0);
      idle(2);
      // Run off the end of the memory, then poke the halted unit.
      idle(26);
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 26'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 26'h1);
      // A backward branch past address zero from PC+4=8 must halt.
      applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0);
      idle(3);
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 26'd0);
      idle(2);
      // Reset dropped in mid-run.
      applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0);
      idle(6);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0);

      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         logic [15:0] bo;
         bo = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20)) - 16'd10;
         applyStimulus(($urandom_range(0, 63) == 0),
                       ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 7) == 0),
                       bo,
                       ($urandom_range(0, 9) == 0),
                       26'($urandom_range(0, 40)));
      end

      repeat (2) @(posedge clk);
      #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
